// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter: data width, FSM states, owner ids.
package mem_port_arbiter_pkg;

  localparam int WORD = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2,
    ARB_DONE = 2'd3
  } arb_state_t;

  localparam logic OWNER_IF  = 1'b0;
  localparam logic OWNER_MEM = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Winner select between fetch and load/store requests.
// MEM_ARB_RR_EN selects round-robin on ties; otherwise MEM always beats IF.
module arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic inst_req,
  input  logic data_req,
  input  logic last_owner,
  output logic pick_valid,
  output logic pick_owner
);

`ifndef MEM_ARB_RR_EN
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
`endif

  always_comb begin
    pick_valid = inst_req | data_req;
    pick_owner = OWNER_IF;
    if (data_req && !inst_req) begin
      pick_owner = OWNER_MEM;
    end else if (data_req && inst_req) begin
`ifdef MEM_ARB_RR_EN
      // On a tie, whoever did not own the last transaction goes next.
      pick_owner = (last_owner == OWNER_MEM) ? OWNER_IF : OWNER_MEM;
`else
      pick_owner = OWNER_MEM;
`endif
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction in flight.
// Tie-break policy is set by MEM_ARB_RR_EN (round-robin when defined, MEM-first otherwise).
//
// state    | meaning
// ARB_IDLE | waiting for a request; winner fields latched on exit
// ARB_REQ  | mem_req high, waiting for mem_gnt
// ARB_RESP | waiting for mem_rvalid
// ARB_DONE | owner's done pulse is high
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_W = WORD
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              inst_req,
  input  logic [DATA_W-1:0] inst_addr,
  output logic              inst_done,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [3:0]        data_wstrb,
  input  logic [DATA_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_done,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_wstrb,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  arb_state_t state_q, state_d;
  logic       pick_valid;
  logic       pick_owner;

  arb_pick u_arb_pick (
    .inst_req   (inst_req),
    .data_req   (data_req),
    .last_owner (owner),
    .pick_valid (pick_valid),
    .pick_owner (pick_owner)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ARB_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (pick_valid) state_d = ARB_REQ;
      ARB_REQ:  if (mem_gnt)    state_d = ARB_RESP;
      ARB_RESP: if (mem_rvalid) state_d = ARB_DONE;
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // Decoded straight from the state flop, so no input reaches these combinationally.
  assign mem_req = (state_q == ARB_REQ);
  assign busy    = (state_q != ARB_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      owner      <= OWNER_IF;
      mem_we     <= 1'b0;
      mem_wstrb  <= 4'h0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      inst_done  <= 1'b0;
      data_done  <= 1'b0;
      inst_rdata <= '0;
      data_rdata <= '0;
    end else begin
      inst_done <= 1'b0;
      data_done <= 1'b0;
      if (state_q == ARB_IDLE && pick_valid) begin
        owner <= pick_owner;
        if (pick_owner == OWNER_MEM) begin
          mem_we    <= data_we;
          mem_wstrb <= data_wstrb;
          mem_addr  <= data_addr;
          mem_wdata <= data_wdata;
        end else begin
          mem_we    <= 1'b0;
          mem_wstrb <= 4'h0;
          mem_addr  <= inst_addr;
          mem_wdata <= '0;
        end
      end
      if (state_q == ARB_RESP && mem_rvalid) begin
        if (owner == OWNER_MEM) begin
          data_done  <= 1'b1;
          data_rdata <= mem_rdata;
        end else begin
          inst_done  <= 1'b1;
          inst_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed cases plus randomized request mixes
// checked against a transaction-level model (winner rule, latency, held rdata).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        inst_req, data_req, data_we, mem_gnt, mem_rvalid;
  logic [31:0] inst_addr, data_addr, data_wdata, mem_rdata;
  logic [3:0]  data_wstrb;
  logic        inst_done, data_done, mem_req, mem_we, busy, owner;
  logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  bit          last_owner = 1'b0;
  logic [31:0] exp_irdata = '0;
  logic [31:0] exp_drdata = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter dut (
    .clk(clk), .rstn(rstn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_done(inst_done), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_we(data_we), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_done(data_done), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_owner"}, {31'd0, owner}, 32'd0);
    chk({tag, "_inst_done"}, {31'd0, inst_done}, 32'd0);
    chk({tag, "_data_done"}, {31'd0, data_done}, 32'd0);
    chk({tag, "_inst_rdata"}, inst_rdata, 32'd0);
    chk({tag, "_data_rdata"}, data_rdata, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_mem_we_wstrb"}, {27'd0, mem_we, mem_wstrb}, 32'd0);
  endtask

  // One complete transaction starting from an IDLE cycle. Requests given here are
  // asserted for the sampling cycle; the winner's request is dropped in its done cycle.
  task automatic txn(input bit ireq, input bit dreq, input logic [31:0] iaddr,
                     input logic [31:0] daddr, input logic dwe, input logic [3:0] dstrb,
                     input logic [31:0] dwdata, input int gw, input int rw,
                     input logic [31:0] rd, output bit win);
    logic [31:0] e_addr, e_wdata;
    logic        e_we;
    logic [3:0]  e_strb;
    int          t0;
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_mem_req", {31'd0, mem_req}, 32'd0);
    chk("idle_dones", {30'd0, inst_done, data_done}, 32'd0);
    inst_req = ireq; inst_addr = iaddr;
    data_req = dreq; data_addr = daddr; data_we = dwe; data_wstrb = dstrb; data_wdata = dwdata;
    if (ireq && dreq) begin
`ifdef MEM_ARB_RR_EN
      win = ~last_owner;
`else
      win = 1'b1;
`endif
    end else begin
      win = dreq;
    end
    e_addr  = win ? daddr  : iaddr;
    e_we    = win ? dwe    : 1'b0;
    e_strb  = win ? dstrb  : 4'h0;
    e_wdata = dwdata;
    t0 = cyc;
    @(negedge clk);
    chk("req_mem_req", {31'd0, mem_req}, 32'd1);
    chk("req_mem_addr", mem_addr, e_addr);
    chk("req_we_wstrb", {27'd0, mem_we, mem_wstrb}, {27'd0, e_we, e_strb});
    if (win) chk("req_mem_wdata", mem_wdata, e_wdata);
    chk("req_owner", {31'd0, owner}, {31'd0, win});
    chk("req_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < gw; i++) begin
      mem_gnt = 1'b0;
      mem_rvalid = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("stall_mem_req", {31'd0, mem_req}, 32'd1);
      chk("stall_mem_addr", mem_addr, e_addr);
      chk("stall_dones", {30'd0, inst_done, data_done}, 32'd0);
    end
    mem_gnt = 1'b1;
    mem_rvalid = 1'($urandom_range(0, 1));
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("resp_mem_req", {31'd0, mem_req}, 32'd0);
    chk("resp_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < rw; i++) begin
      mem_rvalid = 1'b0;
      mem_gnt = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("wait_dones", {30'd0, inst_done, data_done}, 32'd0);
      chk("wait_mem_req", {31'd0, mem_req}, 32'd0);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = rd;
    mem_gnt    = 1'($urandom_range(0, 1));
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_gnt    = 1'b0;
    if (win) exp_drdata = rd; else exp_irdata = rd;
    last_owner = win;
    chk("done_latency", cyc - t0, 3 + gw + rw);
    chk("done_inst_done", {31'd0, inst_done}, {31'd0, ~win});
    chk("done_data_done", {31'd0, data_done}, {31'd0, win});
    chk("done_inst_rdata", inst_rdata, exp_irdata);
    chk("done_data_rdata", data_rdata, exp_drdata);
    if (win) data_req = 1'b0; else inst_req = 1'b0;
  endtask

  initial begin
    bit          w;
    bit          pi, pd;
    logic [31:0] ia, da, dw, rd;
    logic        dwe;
    logic [3:0]  ds;
    pi = 0; pd = 0; ia = '0; da = '0; dw = '0; dwe = 0; ds = '0;

    rstn = 1'b0;
    inst_req = 0; inst_addr = '0; data_req = 0; data_we = 0; data_wstrb = '0;
    data_addr = '0; data_wdata = '0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rstn = 1'b1;

    // single fetch, minimum latency
    txn(1, 0, 32'h1C00_0000, '0, 0, 4'h0, '0, 0, 0, 32'h0280_0000, w);

    // contention: store wins, then the held fetch, then repeated ties
    txn(1, 1, 32'h1C00_0004, 32'h8, 1, 4'hF, 32'hDEAD_BEEF, 0, 0, $urandom, w);
    txn(1, 0, 32'h1C00_0004, '0, 0, 4'h0, '0, 0, 0, $urandom, w);
    txn(1, 1, 32'h1C00_0008, 32'h10, 0, 4'h0, 32'h0, 1, 0, $urandom, w);
    txn(1, 1, 32'h1C00_0008, 32'h14, 1, 4'h3, 32'h1234_5678, 0, 1, $urandom, w);
    txn(1, 1, 32'h1C00_000C, 32'h18, 0, 4'h0, 32'h0, 0, 0, $urandom, w);
    if (w) txn(1, 0, 32'h1C00_000C, '0, 0, 4'h0, '0, 0, 0, $urandom, w);
    else   txn(0, 1, '0, 32'h18, 0, 4'h0, 32'h0, 0, 0, $urandom, w);

    // grant withheld five cycles
    txn(1, 0, 32'h1C00_0100, '0, 0, 4'h0, '0, 5, 0, $urandom, w);

    // store with no byte strobes passes through unchanged
    txn(0, 1, '0, 32'h20, 1, 4'h0, 32'hCAFE_F00D, 0, 2, $urandom, w);

    // spurious rvalid/gnt while idle
    @(negedge clk);
    mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = $urandom;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_gnt = 1'b0;
    chk("spur_dones", {30'd0, inst_done, data_done}, 32'd0);
    chk("spur_busy", {29'd0, busy, mem_req, 1'b0}, 32'd0);
    @(negedge clk);
    chk("spur_dones2", {30'd0, inst_done, data_done}, 32'd0);
    chk("spur_inst_rdata", inst_rdata, exp_irdata);
    chk("spur_data_rdata", data_rdata, exp_drdata);

    // back-to-back loads: new address presented in the done cycle
    txn(0, 1, '0, 32'h100, 0, 4'h0, '0, 0, 0, $urandom, w);
    data_req = 1'b1; data_addr = 32'h104;
    txn(0, 1, '0, 32'h104, 0, 4'h0, '0, 0, 0, $urandom, w);
    @(negedge clk);
    chk("b2b_no_dup", {30'd0, busy, mem_req}, 32'd0);

    // reset while waiting for the response
    inst_req = 1'b1; inst_addr = 32'h1C00_0200;
    @(negedge clk);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    #2 rstn = 1'b0;
    inst_req = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    #1 chk_all_zero("mid_reset");
    @(negedge clk);
    mem_rvalid = 1'b0;
    rstn = 1'b1;
    last_owner = 1'b0; exp_irdata = '0; exp_drdata = '0;
    @(negedge clk);
    chk("post_reset_dones", {30'd0, inst_done, data_done}, 32'd0);
    txn(1, 0, 32'h1C00_0000, '0, 0, 4'h0, '0, 0, 0, $urandom, w);

    // randomized mixes with a held loser
    for (int k = 0; k < 40; k++) begin
      if (!pi && $urandom_range(0, 1) == 1) begin pi = 1; ia = $urandom; end
      if (!pd && $urandom_range(0, 1) == 1) begin
        pd = 1; da = $urandom; dw = $urandom;
        dwe = 1'($urandom_range(0, 1)); ds = 4'($urandom_range(0, 15));
      end
      if (!pi && !pd) begin pi = 1; ia = $urandom; end
      rd = $urandom;
      txn(pi, pd, ia, da, dwe, ds, dw, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rd, w);
      if (w) pd = 0; else pi = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
